// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the 7-segment scan controller
package disp_pkg;
  typedef enum logic {BLANK, ON} state_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

  typedef logic [3:0] nibble_t;

  function automatic nibble_t nibble_of(input logic [15:0] value, input logic [1:0] idx);
    return value[{idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - load request/acknowledge handshake bundle
interface display_scan_ctrl_if;
  logic        load_req;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        lzb_en;
  logic        load_ack;

  modport master (output load_req, output load_data, output load_dp, output lzb_en, input load_ack);
  modport slave  (input load_req, input load_data, input load_dp, input lzb_en, output load_ack);
endinterface

// File: rtl/disp_lzb_mask.sv
// rtl/disp_lzb_mask.sv - leading-zero suppress mask; digit 0 is never suppressed
module disp_lzb_mask
  import disp_pkg::*;
(
  input  logic [15:0]           value,
  input  logic                  lzb,
  output logic [NUM_DIGITS-1:0] mask
);
  logic z3, z2, z1;

  assign z3   = lzb && (value[15:12] == 4'h0);
  assign z2   = z3 && (value[11:8] == 4'h0);
  assign z1   = z2 && (value[7:4] == 4'h0);
  assign mask = {z3, z2, z1, 1'b0};
endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan sequencer with frame-aligned value loading
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 2500
) (
  input  logic                  clkNexys2,
  input  logic                  Reset,
  display_scan_ctrl_if.slave    load,
  output logic [1:0]            selector,
  output nibble_t               digit,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  dp_n,
  output logic                  frame_tick
);
  localparam int CW = $clog2(DWELL_CYC);
  localparam logic [CW-1:0] LAST      = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [1:0]              sel_next;
  logic [15:0]             shadow, shadow_next;
  logic [NUM_DIGITS-1:0]   sdp, sdp_next;
  logic                    slzb, slzb_next;
  logic [NUM_DIGITS-1:0]   mask;
  logic                    slot_end, boundary, commit, lit;
  nibble_t                 digit_next;
  logic [NUM_DIGITS-1:0]   anodes_next;
  logic                    dp_n_next;

  // Mask is taken from the post-commit shadow so a new value blanks correctly from its first slot.
  disp_lzb_mask u_lzb_mask (
    .value (shadow_next),
    .lzb   (slzb_next),
    .mask  (mask)
  );

  always_comb begin
    slot_end    = (cnt == LAST);
    boundary    = slot_end && (selector == 2'd3);
    commit      = boundary && load.load_req;
    cnt_next    = slot_end ? '0 : cnt + 1'b1;
    sel_next    = slot_end ? selector + 2'd1 : selector;
    shadow_next = commit ? load.load_data : shadow;
    sdp_next    = commit ? load.load_dp : sdp;
    slzb_next   = commit ? load.lzb_en : slzb;
    state_next  = (cnt_next >= BLANK_END) ? ON : BLANK;
    lit         = (state_next == ON) && !mask[sel_next];
    digit_next  = nibble_of(shadow_next, sel_next);
    anodes_next = lit ? ~(4'b0001 << sel_next) : ANODES_OFF;
    dp_n_next   = !(lit && sdp_next[sel_next]);
  end

  always_ff @(posedge clkNexys2 or negedge Reset) begin
    if (!Reset) state <= BLANK;
    else        state <= state_next;
  end

  always_ff @(posedge clkNexys2 or negedge Reset) begin
    if (!Reset) begin
      cnt           <= '0;
      selector      <= 2'd0;
      shadow        <= 16'h0000;
      sdp           <= '0;
      slzb          <= 1'b0;
      digit         <= 4'h0;
      anodes        <= ANODES_OFF;
      dp_n          <= 1'b1;
      frame_tick    <= 1'b0;
      load.load_ack <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      selector      <= sel_next;
      shadow        <= shadow_next;
      sdp           <= sdp_next;
      slzb          <= slzb_next;
      digit         <= digit_next;
      anodes        <= anodes_next;
      dp_n          <= dp_n_next;
      frame_tick    <= boundary;
      load.load_ack <= commit;
    end
  end
endmodule
